// File: rtl/simple_fifo.sv
// simple_fifo: single-clock FIFO with registered read data, full/empty and optional almost flags.
module simple_fifo #(
    parameter int DATA_WIDTH             = 8,
    parameter int DEPTH                  = 16,
    parameter bit USE_ALMOST_FLAGS       = 1,
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push, do_pop;

    assign do_push      = push && !full;
    assign do_pop       = pop && !empty;
    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = USE_ALMOST_FLAGS && (32'(count) >= ALMOST_FULL_THRESHOLD);
    assign almost_empty = USE_ALMOST_FLAGS && (32'(count) <= ALMOST_EMPTY_THRESHOLD);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop) begin
                rd_ptr   <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                data_out <= mem[rd_ptr];
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: tb/tb_simple_fifo.sv
// tb_simple_fifo: vector table, corner sequences and randomized traffic against a queue model.
module tb_simple_fifo;
    localparam int D = 16;

    typedef struct {
        bit         push;
        bit         pop;
        logic [7:0] din;
        logic [7:0] dout;
        bit         full;
        bit         empty;
        bit         af;
        bit         ae;
    } vec_t;

    logic       clk = 0, rst_n = 0, push = 0, pop = 0;
    logic [7:0] data_in = 0;
    logic [7:0] data_out, data_out2;
    logic       full, empty, almost_full, almost_empty;
    logic       full2, empty2, almost_full2, almost_empty2;

    int         tests = 0, fails = 0;
    logic [7:0] q[$];
    logic [7:0] m_dout = 0;
    vec_t       vecs[$];

    simple_fifo #(.DATA_WIDTH(8), .DEPTH(D), .USE_ALMOST_FLAGS(1)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    simple_fifo #(.DATA_WIDTH(8), .DEPTH(D), .USE_ALMOST_FLAGS(0)) dut_noaf (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(data_in),
        .data_out(data_out2), .full(full2), .empty(empty2),
        .almost_full(almost_full2), .almost_empty(almost_empty2)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(string name);
        int n = q.size();
        check({name, "_a"}, {data_out, full, empty, almost_full, almost_empty},
              {m_dout, n == D, n == 0, n >= D - 2, n <= 2});
        check({name, "_b"}, {data_out2, full2, empty2, almost_full2, almost_empty2},
              {m_dout, n == D, n == 0, 2'b00});
    endtask

    task automatic cycle(bit p, bit o, logic [7:0] d);
        bit push_ok, pop_ok;
        push = p; pop = o; data_in = d;
        @(posedge clk);
        push_ok = p && q.size() < D;
        pop_ok  = o && q.size() > 0;
        if (pop_ok) m_dout = q.pop_front();
        if (push_ok) q.push_back(d);
        #1;
        push = 0; pop = 0;
        check_model("model");
    endtask

    function automatic void add(bit p, bit o, logic [7:0] din, logic [7:0] dout, int n);
        vecs.push_back('{p, o, din, dout, n == D, n == 0, n >= D - 2, n <= 2});
    endfunction

    initial begin
        // Expected occupancy after each row follows directly from the push/pop sequence.
        for (int i = 0; i < 16; i++) add(1, 0, 8'(i), 8'h00, i + 1);
        add(1, 0, 8'h55, 8'h00, 16);
        for (int j = 0; j < 16; j++) add(0, 1, 8'h00, 8'(j), 15 - j);
        add(0, 1, 8'h00, 8'h0F, 0);
        for (int k = 0; k < 13; k++) add(1, 0, 8'hA0 + 8'(k), 8'h0F, k + 1);
        for (int j = 0; j < 11; j++) add(0, 1, 8'h00, 8'hA0 + 8'(j), 12 - j);
        add(1, 1, 8'hB0, 8'hAB, 2);

        #12;
        check("reset_state", {data_out, full, empty, almost_full, almost_empty}, {8'h00, 4'b0101});
        check("reset_state_noaf", {data_out2, full2, empty2, almost_full2, almost_empty2}, {8'h00, 4'b0100});
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) begin
            cycle(vecs[i].push, vecs[i].pop, vecs[i].din);
            check($sformatf("vec%0d", i), {data_out, full, empty, almost_full, almost_empty},
                  {vecs[i].dout, vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae});
        end

        // Drain AC, B0, then simultaneous push/pop while empty: only the push lands.
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        check("drain_order", data_out, 8'hB0);
        cycle(1, 1, 8'hC0);
        check("simul_empty", {data_out, empty, full}, {8'hB0, 2'b00});
        for (int i = 1; i < D; i++) cycle(1, 0, 8'hC0 + 8'(i));
        check("refill_full", full, 1'b1);
        cycle(1, 1, 8'hEE);
        check("simul_full", {data_out, full, almost_full}, {8'hC0, 2'b01});
        cycle(0, 1, 0);
        check("simul_full_next", data_out, 8'hC1);

        // Asynchronous reset between edges with five words stored.
        while (q.size() > 5) cycle(0, 1, 0);
        #2;
        rst_n = 0;
        #1;
        check("async_reset", {data_out, full, empty, almost_full, almost_empty}, {8'h00, 4'b0101});
        check("async_reset_noaf", {data_out2, full2, empty2, almost_full2, almost_empty2}, {8'h00, 4'b0100});
        q.delete();
        m_dout = 0;
        @(negedge clk);
        rst_n = 1;
        cycle(0, 1, 0);
        check("post_reset_underflow", {data_out, empty}, {8'h00, 1'b1});
        cycle(1, 0, 8'h3C);
        cycle(1, 0, 8'h3D);
        cycle(0, 1, 0);
        check("post_reset_first", data_out, 8'h3C);

        for (int b = 0; b < 8; b++) begin
            int bias = (b % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 400; i++)
                cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
